dragon_game_ctrl: RTL
=====================

# dragon_game_ctrl

Game sequencer for the dragon/snake VGA game. Owns the play state machine (idle, run, pause, over), generates the movement strobe that advances the dragon datapath, arbitrates the debounced direction buttons into a legal heading, and keeps score and speed. It sits between the debounce instances and the dragon position/collision datapath. All logic runs in the 25 MHz pixel clock domain.

## Interface
- TICK_BASE, 2_500_000: move-strobe period in cycles at score 0 (10 Hz at 25 MHz).
- TICK_MIN, 625_000: floor on the move-strobe period.
- TICK_STEP, 125_000: period reduction applied per SPEEDUP_EVERY pears.
- SPEEDUP_EVERY, 4: pears per speed step.
- pixel_clk  in  1  system clock, 25 MHz.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  level; 1 = play enabled (switch[7]).
- pause_btn  in  1  debounced level; its rising edge toggles pause.
- up, down, left, right  in  1 each  debounced button levels.
- collision  in  1  one-cycle pulse from datapath: head hit border or body.
- pear_hit  in  1  one-cycle pulse from datapath: head on pear.
- game_init  out  1  level; datapath holds its initial state while 1.
- move  out  1  one-cycle strobe; datapath advances one cell.
- dir  out  4  one-hot heading: 0001 up, 0010 down, 0100 left, 1000 right.
- game_over  out  1  level; high in OVER.
- paused  out  1  level; high in PAUSE.
- score  out  8  pears eaten, saturating.

## Operation
- States: IDLE, RUN, PAUSE, OVER. Reset enters IDLE.
- IDLE: game_init=1, score=0, dir=1000, speed period=TICK_BASE, tick counter cleared. Go to RUN when start=1.
- RUN: tick counter counts up. When it reaches period-1, assert move for one cycle and wrap to 0.
  - A collision pulse goes to OVER. Collision wins over pear_hit in the same cycle.
  - A pear_hit pulse increments score, saturating at 255. Every SPEEDUP_EVERY-th increment lowers the period by TICK_STEP, clamped at TICK_MIN.
  - A pause_btn rising edge goes to PAUSE.
- PAUSE: tick counter frozen, move never asserted, collision and pear_hit ignored. A pause_btn rising edge returns to RUN with the counter resuming where it stopped.
- OVER: move never asserted; score and dir hold.
- From any non-IDLE state, start=0 goes to IDLE next cycle. This has priority over all other transitions.
- Direction arbitration:
  - pending register captures a button in RUN or IDLE. Priority is up>down>left>right if several are high together; the last capture before the strobe wins.
  - On the move cycle, pending is copied to dir unless it is the reverse of the current dir, in which case it is discarded. pending then clears.
  - At most one turn per move, so a fast double tap cannot reverse the heading.
- Period arithmetic: 22-bit unsigned. The subtract result is compared against TICK_MIN before the update, so there is no underflow.

## Timing
- Reset values: game_init=1, move=0, dir=1000, game_over=0, paused=0, score=0.
- All outputs are registered. dir changes in the same cycle move is high, so the datapath samples the new heading with the strobe.
- State change appears on the outputs one cycle after its cause (start edge, collision, pause edge).
- First move after entering RUN comes exactly `period` cycles after game_init falls.
- score updates one cycle after pear_hit.
- A new period takes effect at the next counter wrap, never mid-interval.
- A pause edge coinciding with the terminal count: pause wins, no move is issued, and the counter holds at period-1.
- Reset mid-game: next cycle equals the reset values, regardless of state.

## Structure
- Package dragon_pkg:
  - state enum (IDLE, RUN, PAUSE, OVER);
  - direction constants DIR_UP/DOWN/LEFT/RIGHT;
  - function is_reverse(a,b).
- Sub-module move_tick_gen:
  - ports pixel_clk, reset_n, enable, clear, period[21:0], tick;
  - contains the counter and wrap logic.
- Top level holds the FSM, the pause edge detector, direction arbitration, score, and the speed register.

## Test plan
Run with TICK_BASE=20, TICK_MIN=8, TICK_STEP=4, SPEEDUP_EVERY=2.
- **Start and first move:** reset, then start=1 -> game_init falls next cycle; first move exactly 20 cycles later; then a move every 20 cycles with dir=1000.
- **Turns and reversal:** dir=1000, pulse left -> next move keeps dir=1000. Pulse up then down before a move -> dir=0010 at that move. After that, pulse left then right in the same interval -> dir=1000 (last capture right; reversal check passes against 0010).
- **Score and speed-up:** 6 pear_hit pulses -> score=6; period steps 20->16->12->8; a 7th and 8th pear keep the period at 8. Preload score=255, then pear_hit -> score stays 255.
- **Game over:** collision and pear_hit in the same cycle -> game_over=1, score unchanged, no further move. Then start=0 -> IDLE with score=0.
- **Pause:** pause edge at counter=10 -> paused=1 and no move for 100 cycles. Collision while paused is ignored. A second pause edge -> next move 10 cycles later.
- **Reset mid-run:** reset_n=0 while RUN at score 3 -> next cycle all outputs equal the reset values.

Source files
------------

// File: rtl/dragon_pkg.sv
// Shared types for the dragon game sequencer: play states, one-hot headings
// and the reversal check used when a queued turn is applied.
package dragon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  function automatic logic is_reverse(input logic [3:0] a, input logic [3:0] b);
    return (a == DIR_UP    && b == DIR_DOWN)  ||
           (a == DIR_DOWN  && b == DIR_UP)    ||
           (a == DIR_LEFT  && b == DIR_RIGHT) ||
           (a == DIR_RIGHT && b == DIR_LEFT);
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Move-strobe timer: counts enabled cycles and flags the last cycle of each
// interval. The period is latched only at clear or wrap so a speed-up never
// cuts an interval short.
module move_tick_gen (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  input  logic [21:0] period,
  output logic        tick
);

  logic [21:0] cnt;
  logic [21:0] cur_period;

  assign tick = enable && (cnt == cur_period - 22'd1);

  always_ff @(posedge pixel_clk) begin
    if (!reset_n || clear || tick) begin
      cnt        <= '0;
      cur_period <= period;
    end else if (enable) begin
      cnt <= cnt + 22'd1;
    end
  end

endmodule

// File: rtl/dragon_game_ctrl.sv
// Dragon game sequencer: play FSM, move strobe, heading arbitration, score/speed.
// IDLE: datapath held in init | RUN: moving | PAUSE: frozen | OVER: crashed, waiting for start=0
module dragon_game_ctrl
  import dragon_pkg::*;
#(
  parameter int TICK_BASE     = 2_500_000,
  parameter int TICK_MIN      = 625_000,
  parameter int TICK_STEP     = 125_000,
  parameter int SPEEDUP_EVERY = 4
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause_btn,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       collision,
  input  logic       pear_hit,
  output logic       game_init,
  output logic       move,
  output logic [3:0] dir,
  output logic       game_over,
  output logic       paused,
  output logic [7:0] score
);

  localparam int DIV_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEEDUP_EVERY - 1);
  localparam logic [21:0] BASE_P  = 22'(TICK_BASE);
  localparam logic [21:0] MIN_P   = 22'(TICK_MIN);
  localparam logic [21:0] STEP_P  = 22'(TICK_STEP);
  localparam logic [21:0] FLOOR_P = 22'(TICK_MIN + TICK_STEP);

  state_t           state, state_next;
  logic             pause_q, pause_rise;
  logic [3:0]       pending, btn_dir;
  logic [21:0]      speed;
  logic [DIV_W-1:0] pear_div;
  logic             tick, tick_en, score_inc;

  assign pause_rise = pause_btn && !pause_q;
  // A pause edge or crash on the terminal count suppresses that move.
  assign tick_en    = (state == RUN) && start && !collision && !pause_rise;
  assign score_inc  = (state == RUN) && start && !collision && pear_hit && (score != 8'hFF);

  move_tick_gen u_tick (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .enable    (tick_en),
    .clear     (state == IDLE),
    .period    (speed),
    .tick      (tick)
  );

  always_comb begin
    state_next = state;
    if (state != IDLE && !start) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (collision) state_next = OVER;
                 else if (pause_rise) state_next = PAUSE;
        PAUSE:   if (pause_rise) state_next = RUN;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    btn_dir = DIR_NONE;
    if (up)         btn_dir = DIR_UP;
    else if (down)  btn_dir = DIR_DOWN;
    else if (left)  btn_dir = DIR_LEFT;
    else if (right) btn_dir = DIR_RIGHT;
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pause_q   <= 1'b0;
      game_init <= 1'b1;
      game_over <= 1'b0;
      paused    <= 1'b0;
      move      <= 1'b0;
      dir       <= DIR_RIGHT;
      pending   <= DIR_NONE;
      score     <= '0;
      speed     <= BASE_P;
      pear_div  <= '0;
    end else begin
      state     <= state_next;
      pause_q   <= pause_btn;
      game_init <= (state_next == IDLE);
      game_over <= (state_next == OVER);
      paused    <= (state_next == PAUSE);
      move      <= tick;
      if (state_next == IDLE) begin
        dir      <= DIR_RIGHT;
        score    <= '0;
        speed    <= BASE_P;
        pear_div <= '0;
        if (state != IDLE)
          pending <= DIR_NONE;
        else if (btn_dir != DIR_NONE)
          pending <= btn_dir;
      end else begin
        // One turn per move: the queued heading is consumed by every strobe.
        if (tick) begin
          if (pending != DIR_NONE && !is_reverse(pending, dir))
            dir <= pending;
          pending <= btn_dir;
        end else if ((state == RUN || state == IDLE) && btn_dir != DIR_NONE) begin
          pending <= btn_dir;
        end
        if (score_inc) begin
          score <= score + 8'd1;
          if (pear_div == DIV_LAST) begin
            pear_div <= '0;
            speed    <= (speed >= FLOOR_P) ? (speed - STEP_P) : MIN_P;
          end else begin
            pear_div <= pear_div + DIV_W'(1);
          end
        end
      end
    end
  end

endmodule
